ddrc_rst_seq_ctrl: RTL and testbench
====================================

// Module: ddrc_rst_seq_ctrl
// PURPOSE
//  Parametrised DDR controller reset/init sequencer, successor to the fixed 3-port sequencer.
//  Drives APB/core/AXI resets into the DDRC and hands the DDRC APB port to an external init engine.
//  Once the engine reports done, it switches the APB port to the user. Adds N AXI ports,
//  programmable hold counts, init timeout with error state, and user-requested re-initialisation.
// PARAMETERS
//  NUM_AXI          3   number of AXI reset channels, 1..8
//  PRST_ASSERT_CYC  15  cycles after reset release before ddrc_preset deasserts
//  PRST_RELEASE_CYC 30  cycles after reset release before eng_presetn/eng_start assert; must be > PRST_ASSERT_CYC
//  CORE_QUIET_CYC   30  engine-write-free cycles in INIT before core/AXI resets deassert
//  INIT_TIMEOUT     0   max INIT cycles before ERR; 0 disables the timeout; 24-bit counter
//  APB_AW           12  APB address width
//  APB_DW           32  APB data width
// PORTS
//  pclk             in   1        clock
//  resetn           in   1        async active-low reset
//  user_psel/penable/pwrite  in  1  user APB controls
//  user_paddr       in   APB_AW   user APB address
//  user_pwdata      in   APB_DW   user APB write data
//  user_prdata      out  APB_DW   = ddrc_prdata (pass-through)
//  user_pready      out  1        ddrc_pready in DONE, else 0
//  user_preset      in   1        user APB reset, used in DONE
//  user_ddrc_rst    in   1        user core reset, used in DONE
//  user_axi_rst     in   NUM_AXI  user AXI resets, used in DONE
//  reinit_req       in   1        single-cycle pulse; requests full re-init
//  eng_presetn      out  1        init-engine reset, active low
//  eng_start        out  1        init engine enable
//  eng_psel/penable/pwrite  in  1  init-engine APB controls
//  eng_paddr/eng_pwdata  in  APB_AW/APB_DW  init-engine APB address/data
//  eng_done         in   1        engine finished, level
//  ddrc_preset      out  1        DDRC APB reset, active high
//  ddrc_rst         out  1        DDRC core reset, active high
//  ddrc_axi_rst     out  NUM_AXI  DDRC AXI resets, active high
//  ddrc_psel/penable/pwrite  out  1  muxed APB controls
//  ddrc_paddr/ddrc_pwdata  out  APB_AW/APB_DW  muxed APB address/data
//  ddrc_prdata      in   APB_DW   DDRC APB read data
//  ddrc_pready      in   1        DDRC APB ready
//  ddr_init_done    out  1        init complete, sequencer in DONE
//  init_err         out  1        sticky; INIT timed out
// BEHAVIOUR
//  Reset values:
//  - State PRST; counters 0.
//  - ddrc_preset=1, ddrc_rst=1, ddrc_axi_rst=all 1.
//  - eng_presetn=0, eng_start=0, ddr_init_done=0, init_err=0.
//  States:
//  - PRST:
//    - seq_cnt increments each cycle.
//    - ddrc_preset clears on the edge where seq_cnt==PRST_ASSERT_CYC.
//    - When seq_cnt==PRST_RELEASE_CYC: eng_presetn=1, eng_start=1, clear counters, go to INIT.
//  - INIT:
//    - quiet_cnt clears on eng_psel&eng_pwrite, else increments and saturates at CORE_QUIET_CYC.
//    - At saturation, ddrc_rst and all ddrc_axi_rst clear. They stay clear until leaving INIT.
//    - eng_done=1 -> DONE next edge.
//    - If INIT_TIMEOUT!=0 and tmo_cnt==INIT_TIMEOUT-1 with eng_done=0 -> ERR.
//  - DONE:
//    - ddr_init_done=1, eng_start=0.
//    - ddrc_preset/rst/axi_rst and APB outputs follow user_* combinationally.
//  - ERR:
//    - init_err=1, eng_start=0, eng_presetn=0.
//    - ddrc_preset, ddrc_rst and ddrc_axi_rst all 1.
//  APB mux:
//  - In PRST/INIT/ERR, ddrc_p* follow eng_p* (engine in reset in PRST/ERR, so idle).
//  - In DONE, ddrc_p* follow user_p*. The select is registered state; no same-cycle glitch.
//  Re-init:
//  - reinit_req in DONE sets reinit_pend.
//  - When reinit_pend=1 and user_psel=0 (no APB transfer in flight): go to PRST with seq_cnt=0.
//    On entry: ddr_init_done=0; preset/rst/axi_rst reassert; eng_presetn=0; reinit_pend clears.
//  - reinit_req in ERR -> PRST, init_err clears.
//  - reinit_req in PRST/INIT is ignored.
//  - eng_done and timeout on the same edge: done wins.
//  - resetn low in any state: immediate return to reset values.
// STRUCTURE
//  - Shared package ddrc_pkg: state enum (PRST, INIT, DONE, ERR) and the 24-bit counter width constant.
//  - Sub-module ddrc_apb_mux: parametrised APB_AW/APB_DW 2:1 APB mux with pready gating.
//  - FSM and counters live in this module.
// TESTING
//  1. Defaults, eng_done at INIT cycle 50 -> ddrc_preset falls at cycle 15.
//     eng_start rises at 30; ddr_init_done rises 1 cycle after eng_done; APB follows user.
//  2. Engine writes at INIT cycles 5 and 20 -> ddrc_rst/axi_rst clear exactly 30 cycles after the last write.
//  3. INIT_TIMEOUT=100, eng_done never -> ERR after 100 INIT cycles, init_err=1, resets high.
//     Then reinit_req -> PRST, init_err=0.
//  4. reinit_req in DONE while user_psel=1 for 3 cycles -> PRST entered only after user_psel drops.
//     ddr_init_done then 0.
//  5. NUM_AXI=5, user_axi_rst=5'b10101 in DONE -> ddrc_axi_rst=5'b10101.
//     resetn pulse mid-INIT -> all outputs return to reset values.

Source files
------------

// File: rtl/ddrc_pkg.sv
// Shared types for the DDR controller reset/init sequencer.
// Sequencer state encoding and counter width.
package ddrc_pkg;

   localparam int CNT_W = 24;

   typedef enum logic [1:0] {
      ST_PRST,
      ST_INIT,
      ST_DONE,
      ST_ERR
   } state_t;

endpackage

// File: rtl/ddrc_apb_mux.sv
// 2:1 APB mux handing the DDRC APB port to the init engine or the user.
// Select comes from registered state, so the switch is glitch-free.
module ddrc_apb_mux #(
   parameter int APB_AW = 12,
   parameter int APB_DW = 32
) (
   input  logic              sel_user,
   input  logic              user_psel,
   input  logic              user_penable,
   input  logic              user_pwrite,
   input  logic [APB_AW-1:0] user_paddr,
   input  logic [APB_DW-1:0] user_pwdata,
   output logic [APB_DW-1:0] user_prdata,
   output logic              user_pready,
   input  logic              eng_psel,
   input  logic              eng_penable,
   input  logic              eng_pwrite,
   input  logic [APB_AW-1:0] eng_paddr,
   input  logic [APB_DW-1:0] eng_pwdata,
   output logic              ddrc_psel,
   output logic              ddrc_penable,
   output logic              ddrc_pwrite,
   output logic [APB_AW-1:0] ddrc_paddr,
   output logic [APB_DW-1:0] ddrc_pwdata,
   input  logic [APB_DW-1:0] ddrc_prdata,
   input  logic              ddrc_pready
);

   always_comb begin
      if (sel_user) begin
         ddrc_psel    = user_psel;
         ddrc_penable = user_penable;
         ddrc_pwrite  = user_pwrite;
         ddrc_paddr   = user_paddr;
         ddrc_pwdata  = user_pwdata;
      end else begin
         ddrc_psel    = eng_psel;
         ddrc_penable = eng_penable;
         ddrc_pwrite  = eng_pwrite;
         ddrc_paddr   = eng_paddr;
         ddrc_pwdata  = eng_pwdata;
      end
   end

   assign user_prdata = ddrc_prdata;
   assign user_pready = sel_user & ddrc_pready;

endmodule

// File: rtl/ddrc_rst_seq_ctrl.sv
// DDR controller reset/init sequencer: drives DDRC resets, runs the init
// engine, then hands the APB port to the user; supports timeout and re-init.
module ddrc_rst_seq_ctrl
   import ddrc_pkg::*;
#(
   parameter int NUM_AXI          = 3,
   parameter int PRST_ASSERT_CYC  = 15,
   parameter int PRST_RELEASE_CYC = 30,
   parameter int CORE_QUIET_CYC   = 30,
   parameter int INIT_TIMEOUT     = 0,
   parameter int APB_AW           = 12,
   parameter int APB_DW           = 32
) (
   input  logic               pclk,
   input  logic               resetn,
   input  logic               user_psel,
   input  logic               user_penable,
   input  logic               user_pwrite,
   input  logic [APB_AW-1:0]  user_paddr,
   input  logic [APB_DW-1:0]  user_pwdata,
   output logic [APB_DW-1:0]  user_prdata,
   output logic               user_pready,
   input  logic               user_preset,
   input  logic               user_ddrc_rst,
   input  logic [NUM_AXI-1:0] user_axi_rst,
   input  logic               reinit_req,
   output logic               eng_presetn,
   output logic               eng_start,
   input  logic               eng_psel,
   input  logic               eng_penable,
   input  logic               eng_pwrite,
   input  logic [APB_AW-1:0]  eng_paddr,
   input  logic [APB_DW-1:0]  eng_pwdata,
   input  logic               eng_done,
   output logic               ddrc_preset,
   output logic               ddrc_rst,
   output logic [NUM_AXI-1:0] ddrc_axi_rst,
   output logic               ddrc_psel,
   output logic               ddrc_penable,
   output logic               ddrc_pwrite,
   output logic [APB_AW-1:0]  ddrc_paddr,
   output logic [APB_DW-1:0]  ddrc_pwdata,
   input  logic [APB_DW-1:0]  ddrc_prdata,
   input  logic               ddrc_pready,
   output logic               ddr_init_done,
   output logic               init_err
);

   localparam logic [CNT_W-1:0] ASSERT_C = CNT_W'(PRST_ASSERT_CYC);
   localparam logic [CNT_W-1:0] REL_C    = CNT_W'(PRST_RELEASE_CYC);
   localparam logic [CNT_W-1:0] QUIET_C  = CNT_W'(CORE_QUIET_CYC);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam bit               TMO_EN   = (INIT_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TMO_LAST =
      CNT_W'((INIT_TIMEOUT > 0) ? INIT_TIMEOUT - 1 : 0);

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] seq_cnt;
   logic [CNT_W-1:0] seq_n;
   logic [CNT_W-1:0] quiet_cnt;
   logic [CNT_W-1:0] quiet_n;
   logic [CNT_W-1:0] tmo_cnt;
   logic [CNT_W-1:0] tmo_n;
   logic             reinit_pend;
   logic             pend_n;
   logic             core_rel;
   logic             rel_n;
   logic             quiet_sat;
   logic             eng_wr;

   assign eng_wr    = eng_psel & eng_pwrite;
   assign quiet_sat = (quiet_cnt == QUIET_C);

   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_PRST;
         seq_cnt     <= '0;
         quiet_cnt   <= '0;
         tmo_cnt     <= '0;
         reinit_pend <= 1'b0;
         core_rel    <= 1'b0;
      end else begin
         state       <= state_n;
         seq_cnt     <= seq_n;
         quiet_cnt   <= quiet_n;
         tmo_cnt     <= tmo_n;
         reinit_pend <= pend_n;
         core_rel    <= rel_n;
      end
   end

   always_comb begin
      state_n = state;
      seq_n   = seq_cnt;
      quiet_n = quiet_cnt;
      tmo_n   = tmo_cnt;
      pend_n  = reinit_pend;
      rel_n   = core_rel;
      unique case (state)
         ST_PRST: begin
            pend_n = 1'b0;
            if (seq_cnt == REL_C) begin
               state_n = ST_INIT;
               seq_n   = '0;
               quiet_n = '0;
               tmo_n   = '0;
               rel_n   = 1'b0;
            end else begin
               seq_n = seq_cnt + ONE;
            end
         end
         ST_INIT: begin
            if (eng_wr)
               quiet_n = '0;
            else if (!quiet_sat)
               quiet_n = quiet_cnt + ONE;
            // Once released, core/AXI stay out of reset for the rest of INIT
            if (quiet_sat)
               rel_n = 1'b1;
            if (tmo_cnt != '1)
               tmo_n = tmo_cnt + ONE;
            if (eng_done)
               state_n = ST_DONE;
            else if (TMO_EN && (tmo_cnt == TMO_LAST))
               state_n = ST_ERR;
         end
         ST_DONE: begin
            if (reinit_req)
               pend_n = 1'b1;
            if (reinit_pend && !user_psel) begin
               state_n = ST_PRST;
               seq_n   = '0;
               pend_n  = 1'b0;
            end
         end
         ST_ERR: begin
            if (reinit_req) begin
               state_n = ST_PRST;
               seq_n   = '0;
            end
         end
         default: state_n = ST_PRST;
      endcase
   end

   always_comb begin
      ddrc_preset  = 1'b1;
      ddrc_rst     = 1'b1;
      ddrc_axi_rst = '1;
      unique case (state)
         ST_PRST: ddrc_preset = (seq_cnt <= ASSERT_C);
         ST_INIT: begin
            ddrc_preset  = 1'b0;
            ddrc_rst     = !(core_rel || quiet_sat);
            ddrc_axi_rst = {NUM_AXI{!(core_rel || quiet_sat)}};
         end
         ST_DONE: begin
            ddrc_preset  = user_preset;
            ddrc_rst     = user_ddrc_rst;
            ddrc_axi_rst = user_axi_rst;
         end
         ST_ERR: begin
            ddrc_preset  = 1'b1;
            ddrc_rst     = 1'b1;
            ddrc_axi_rst = '1;
         end
         default: begin
            ddrc_preset  = 1'b1;
            ddrc_rst     = 1'b1;
            ddrc_axi_rst = '1;
         end
      endcase
   end

   assign eng_presetn   = (state == ST_INIT) || (state == ST_DONE);
   assign eng_start     = (state == ST_INIT);
   assign ddr_init_done = (state == ST_DONE);
   assign init_err      = (state == ST_ERR);

   ddrc_apb_mux #(
      .APB_AW (APB_AW),
      .APB_DW (APB_DW)
   ) u_apb_mux (
      .sel_user     (state == ST_DONE),
      .user_psel    (user_psel),
      .user_penable (user_penable),
      .user_pwrite  (user_pwrite),
      .user_paddr   (user_paddr),
      .user_pwdata  (user_pwdata),
      .user_prdata  (user_prdata),
      .user_pready  (user_pready),
      .eng_psel     (eng_psel),
      .eng_penable  (eng_penable),
      .eng_pwrite   (eng_pwrite),
      .eng_paddr    (eng_paddr),
      .eng_pwdata   (eng_pwdata),
      .ddrc_psel    (ddrc_psel),
      .ddrc_penable (ddrc_penable),
      .ddrc_pwrite  (ddrc_pwrite),
      .ddrc_paddr   (ddrc_paddr),
      .ddrc_pwdata  (ddrc_pwdata),
      .ddrc_prdata  (ddrc_prdata),
      .ddrc_pready  (ddrc_pready)
   );

endmodule

// File: tb/tb_ddrc_rst_seq_ctrl.sv
// Directed bench for the DDRC reset/init sequencer.
// One task per scenario; expected values are hand-derived cycle counts.
module tb_ddrc_rst_seq_ctrl;

   logic        pclk = 1'b0;
   logic        resetn;
   logic        user_psel, user_penable, user_pwrite;
   logic [11:0] user_paddr;
   logic [31:0] user_pwdata;
   logic [31:0] user_prdata;
   logic        user_pready;
   logic        user_preset, user_ddrc_rst;
   logic [4:0]  user_axi_rst;
   logic        reinit_req;
   logic        eng_presetn, eng_start;
   logic        eng_psel, eng_penable, eng_pwrite;
   logic [11:0] eng_paddr;
   logic [31:0] eng_pwdata;
   logic        eng_done;
   logic        ddrc_preset, ddrc_rst;
   logic [4:0]  ddrc_axi_rst;
   logic        ddrc_psel, ddrc_penable, ddrc_pwrite;
   logic [11:0] ddrc_paddr;
   logic [31:0] ddrc_pwdata;
   logic [31:0] ddrc_prdata;
   logic        ddrc_pready;
   logic        ddr_init_done, init_err;

   int chk  = 0;
   int pass = 0;

   always #5 pclk = ~pclk;

   ddrc_rst_seq_ctrl #(
      .NUM_AXI      (5),
      .INIT_TIMEOUT (100)
   ) dut (
      .pclk          (pclk),
      .resetn        (resetn),
      .user_psel     (user_psel),
      .user_penable  (user_penable),
      .user_pwrite   (user_pwrite),
      .user_paddr    (user_paddr),
      .user_pwdata   (user_pwdata),
      .user_prdata   (user_prdata),
      .user_pready   (user_pready),
      .user_preset   (user_preset),
      .user_ddrc_rst (user_ddrc_rst),
      .user_axi_rst  (user_axi_rst),
      .reinit_req    (reinit_req),
      .eng_presetn   (eng_presetn),
      .eng_start     (eng_start),
      .eng_psel      (eng_psel),
      .eng_penable   (eng_penable),
      .eng_pwrite    (eng_pwrite),
      .eng_paddr     (eng_paddr),
      .eng_pwdata    (eng_pwdata),
      .eng_done      (eng_done),
      .ddrc_preset   (ddrc_preset),
      .ddrc_rst      (ddrc_rst),
      .ddrc_axi_rst  (ddrc_axi_rst),
      .ddrc_psel     (ddrc_psel),
      .ddrc_penable  (ddrc_penable),
      .ddrc_pwrite   (ddrc_pwrite),
      .ddrc_paddr    (ddrc_paddr),
      .ddrc_pwdata   (ddrc_pwdata),
      .ddrc_prdata   (ddrc_prdata),
      .ddrc_pready   (ddrc_pready),
      .ddr_init_done (ddr_init_done),
      .init_err      (init_err)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic idle_inputs();
      user_psel     = 0; user_penable = 0; user_pwrite = 0;
      user_paddr    = '0; user_pwdata = '0;
      user_preset   = 0; user_ddrc_rst = 0; user_axi_rst = '0;
      reinit_req    = 0;
      eng_psel      = 0; eng_penable = 0; eng_pwrite = 0;
      eng_paddr     = '0; eng_pwdata = '0; eng_done = 0;
      ddrc_prdata   = '0; ddrc_pready = 0;
   endtask

   // Full reset then 31 edges: leaves the DUT in INIT cycle 0.
   task automatic start_seq();
      resetn = 0;
      tick(); tick();
      resetn = 1;
      repeat (31) tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 0;
      #2;
      chk++; if (ddrc_preset !== 1'b1) $display("FAIL rst_preset: got %b exp 1", ddrc_preset); else pass++;
      chk++; if (ddrc_rst !== 1'b1) $display("FAIL rst_core: got %b exp 1", ddrc_rst); else pass++;
      chk++; if (ddrc_axi_rst !== 5'h1f) $display("FAIL rst_axi: got %h exp 1f", ddrc_axi_rst); else pass++;
      chk++; if (eng_presetn !== 1'b0) $display("FAIL rst_eng_presetn: got %b exp 0", eng_presetn); else pass++;
      chk++; if (eng_start !== 1'b0) $display("FAIL rst_eng_start: got %b exp 0", eng_start); else pass++;
      chk++; if (ddr_init_done !== 1'b0) $display("FAIL rst_done: got %b exp 0", ddr_init_done); else pass++;
      chk++; if (init_err !== 1'b0) $display("FAIL rst_err: got %b exp 0", init_err); else pass++;
      tick(); tick();
      resetn = 1;
      repeat (15) tick();
      chk++; if (ddrc_preset !== 1'b1) $display("FAIL preset_c15: got %b exp 1", ddrc_preset); else pass++;
      tick();
      chk++; if (ddrc_preset !== 1'b0) $display("FAIL preset_c16: got %b exp 0", ddrc_preset); else pass++;
      chk++; if (ddrc_rst !== 1'b1) $display("FAIL core_in_prst: got %b exp 1", ddrc_rst); else pass++;
      repeat (14) tick();
      chk++; if (eng_start !== 1'b0) $display("FAIL start_c30: got %b exp 0", eng_start); else pass++;
      tick();
      chk++; if (eng_start !== 1'b1) $display("FAIL start_c31: got %b exp 1", eng_start); else pass++;
      chk++; if (eng_presetn !== 1'b1) $display("FAIL presetn_c31: got %b exp 1", eng_presetn); else pass++;
   endtask

   task automatic test_init_done();
      eng_psel = 1; eng_paddr = 12'h123; ddrc_pready = 1;
      #1;
      chk++; if (ddrc_paddr !== 12'h123) $display("FAIL init_mux_addr: got %h exp 123", ddrc_paddr); else pass++;
      chk++; if (ddrc_psel !== 1'b1) $display("FAIL init_mux_psel: got %b exp 1", ddrc_psel); else pass++;
      chk++; if (user_pready !== 1'b0) $display("FAIL init_user_pready: got %b exp 0", user_pready); else pass++;
      eng_psel = 0;
      for (int c = 0; c < 50; c++) begin
         if (c == 29) begin
            chk++; if (ddrc_rst !== 1'b1) $display("FAIL quiet_c29: got %b exp 1", ddrc_rst); else pass++;
         end
         if (c == 30) begin
            chk++; if (ddrc_rst !== 1'b0) $display("FAIL quiet_c30: got %b exp 0", ddrc_rst); else pass++;
            chk++; if (ddrc_axi_rst !== 5'h00) $display("FAIL quiet_axi_c30: got %h exp 00", ddrc_axi_rst); else pass++;
         end
         tick();
      end
      eng_done = 1;
      #1;
      chk++; if (ddr_init_done !== 1'b0) $display("FAIL done_early: got %b exp 0", ddr_init_done); else pass++;
      tick();
      eng_done = 0;
      chk++; if (ddr_init_done !== 1'b1) $display("FAIL done_c51: got %b exp 1", ddr_init_done); else pass++;
      chk++; if (eng_start !== 1'b0) $display("FAIL done_start: got %b exp 0", eng_start); else pass++;
      user_psel = 1; user_penable = 1; user_pwrite = 1;
      user_paddr = 12'habc; user_pwdata = 32'hdeadbeef;
      ddrc_prdata = 32'h5a5a0001; user_preset = 1;
      #1;
      chk++; if (ddrc_paddr !== 12'habc) $display("FAIL user_addr: got %h exp abc", ddrc_paddr); else pass++;
      chk++; if (ddrc_pwdata !== 32'hdeadbeef) $display("FAIL user_wdata: got %h exp deadbeef", ddrc_pwdata); else pass++;
      chk++; if (ddrc_penable !== 1'b1) $display("FAIL user_penable: got %b exp 1", ddrc_penable); else pass++;
      chk++; if (user_pready !== 1'b1) $display("FAIL user_pready: got %b exp 1", user_pready); else pass++;
      chk++; if (user_prdata !== 32'h5a5a0001) $display("FAIL user_prdata: got %h exp 5a5a0001", user_prdata); else pass++;
      chk++; if (ddrc_preset !== 1'b1) $display("FAIL user_preset: got %b exp 1", ddrc_preset); else pass++;
      chk++; if (ddrc_rst !== 1'b0) $display("FAIL user_core: got %b exp 0", ddrc_rst); else pass++;
      idle_inputs();
   endtask

   task automatic test_quiet_writes();
      start_seq();
      for (int c = 0; c < 60; c++) begin
         eng_psel   = (c == 5) || (c == 20) || (c == 55);
         eng_pwrite = eng_psel;
         reinit_req = (c == 10);
         #1;
         if (c == 11) begin
            chk++; if (eng_start !== 1'b1) $display("FAIL reinit_ignored: got %b exp 1", eng_start); else pass++;
         end
         if (c == 40) begin
            chk++; if (ddrc_rst !== 1'b1) $display("FAIL qw_c40: got %b exp 1", ddrc_rst); else pass++;
         end
         if (c == 50) begin
            chk++; if (ddrc_rst !== 1'b1) $display("FAIL qw_c50: got %b exp 1", ddrc_rst); else pass++;
         end
         if (c == 51) begin
            chk++; if (ddrc_rst !== 1'b0) $display("FAIL qw_c51: got %b exp 0", ddrc_rst); else pass++;
            chk++; if (ddrc_axi_rst !== 5'h00) $display("FAIL qw_axi_c51: got %h exp 00", ddrc_axi_rst); else pass++;
         end
         if (c == 58) begin
            chk++; if (ddrc_rst !== 1'b0) $display("FAIL qw_sticky: got %b exp 0", ddrc_rst); else pass++;
         end
         tick();
      end
      idle_inputs();
      eng_done = 1;
      tick();
      eng_done = 0;
      chk++; if (ddr_init_done !== 1'b1) $display("FAIL qw_done: got %b exp 1", ddr_init_done); else pass++;
   endtask

   task automatic test_reinit();
      user_psel = 1; reinit_req = 1;
      tick();
      reinit_req = 0;
      chk++; if (ddr_init_done !== 1'b1) $display("FAIL ri_c1: got %b exp 1", ddr_init_done); else pass++;
      tick();
      chk++; if (ddr_init_done !== 1'b1) $display("FAIL ri_c2: got %b exp 1", ddr_init_done); else pass++;
      tick();
      user_psel = 0;
      #1;
      chk++; if (ddr_init_done !== 1'b1) $display("FAIL ri_c3: got %b exp 1", ddr_init_done); else pass++;
      tick();
      chk++; if (ddr_init_done !== 1'b0) $display("FAIL ri_c4: got %b exp 0", ddr_init_done); else pass++;
      chk++; if (ddrc_preset !== 1'b1) $display("FAIL ri_preset: got %b exp 1", ddrc_preset); else pass++;
      chk++; if (ddrc_axi_rst !== 5'h1f) $display("FAIL ri_axi: got %h exp 1f", ddrc_axi_rst); else pass++;
      chk++; if (eng_presetn !== 1'b0) $display("FAIL ri_presetn: got %b exp 0", eng_presetn); else pass++;
      repeat (30) tick();
      chk++; if (eng_start !== 1'b0) $display("FAIL ri_start30: got %b exp 0", eng_start); else pass++;
      tick();
      chk++; if (eng_start !== 1'b1) $display("FAIL ri_start31: got %b exp 1", eng_start); else pass++;
   endtask

   task automatic test_timeout();
      start_seq();
      repeat (99) tick();
      chk++; if (init_err !== 1'b0) $display("FAIL tmo_c99: got %b exp 0", init_err); else pass++;
      chk++; if (ddrc_rst !== 1'b0) $display("FAIL tmo_core_c99: got %b exp 0", ddrc_rst); else pass++;
      tick();
      chk++; if (init_err !== 1'b1) $display("FAIL tmo_c100: got %b exp 1", init_err); else pass++;
      chk++; if (eng_start !== 1'b0) $display("FAIL tmo_start: got %b exp 0", eng_start); else pass++;
      chk++; if (eng_presetn !== 1'b0) $display("FAIL tmo_presetn: got %b exp 0", eng_presetn); else pass++;
      chk++; if (ddrc_preset !== 1'b1) $display("FAIL tmo_preset: got %b exp 1", ddrc_preset); else pass++;
      chk++; if (ddrc_rst !== 1'b1) $display("FAIL tmo_core: got %b exp 1", ddrc_rst); else pass++;
      chk++; if (ddrc_axi_rst !== 5'h1f) $display("FAIL tmo_axi: got %h exp 1f", ddrc_axi_rst); else pass++;
      repeat (5) tick();
      chk++; if (init_err !== 1'b1) $display("FAIL tmo_sticky: got %b exp 1", init_err); else pass++;
      reinit_req = 1;
      tick();
      reinit_req = 0;
      chk++; if (init_err !== 1'b0) $display("FAIL err_reinit: got %b exp 0", init_err); else pass++;
      chk++; if (ddrc_preset !== 1'b1) $display("FAIL err_reinit_preset: got %b exp 1", ddrc_preset); else pass++;
      repeat (31) tick();
      chk++; if (eng_start !== 1'b1) $display("FAIL err_restart: got %b exp 1", eng_start); else pass++;
   endtask

   task automatic test_done_vs_tmo();
      start_seq();
      repeat (99) tick();
      eng_done = 1;
      tick();
      eng_done = 0;
      chk++; if (ddr_init_done !== 1'b1) $display("FAIL race_done: got %b exp 1", ddr_init_done); else pass++;
      chk++; if (init_err !== 1'b0) $display("FAIL race_err: got %b exp 0", init_err); else pass++;
   endtask

   task automatic test_axi_and_reset();
      user_axi_rst = 5'b10101;
      #1;
      chk++; if (ddrc_axi_rst !== 5'b10101) $display("FAIL axi_user: got %b exp 10101", ddrc_axi_rst); else pass++;
      user_axi_rst = 5'b01010;
      #1;
      chk++; if (ddrc_axi_rst !== 5'b01010) $display("FAIL axi_user2: got %b exp 01010", ddrc_axi_rst); else pass++;
      idle_inputs();
      start_seq();
      repeat (40) tick();
      chk++; if (ddrc_rst !== 1'b0) $display("FAIL mid_init_core: got %b exp 0", ddrc_rst); else pass++;
      resetn = 0;
      #2;
      chk++; if (ddrc_preset !== 1'b1) $display("FAIL ar_preset: got %b exp 1", ddrc_preset); else pass++;
      chk++; if (ddrc_rst !== 1'b1) $display("FAIL ar_core: got %b exp 1", ddrc_rst); else pass++;
      chk++; if (ddrc_axi_rst !== 5'h1f) $display("FAIL ar_axi: got %h exp 1f", ddrc_axi_rst); else pass++;
      chk++; if (eng_presetn !== 1'b0) $display("FAIL ar_presetn: got %b exp 0", eng_presetn); else pass++;
      chk++; if (eng_start !== 1'b0) $display("FAIL ar_start: got %b exp 0", eng_start); else pass++;
      chk++; if (ddr_init_done !== 1'b0) $display("FAIL ar_done: got %b exp 0", ddr_init_done); else pass++;
      chk++; if (init_err !== 1'b0) $display("FAIL ar_err: got %b exp 0", init_err); else pass++;
      tick();
      resetn = 1;
      repeat (16) tick();
      chk++; if (ddrc_preset !== 1'b0) $display("FAIL ar_restart: got %b exp 0", ddrc_preset); else pass++;
   endtask

   initial begin
      resetn = 0;
      idle_inputs();
      test_reset();
      test_init_done();
      test_quiet_writes();
      test_reinit();
      test_timeout();
      test_done_vs_tmo();
      test_axi_and_reset();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

endmodule
